sram_responder: RTL
===================

Name: sram_responder

Overview:
- Memory-side responder for the CPU's two SRAM initiator interfaces: instruction port (read-only) and data port (read/write, byte enables).
- Holds a single word-organised array shared by both ports. Returns read data with a fixed 1-cycle latency, which is the timing the CPU's fetch and MEM stages are built around.
- Sits at SoC level beside the CPU. On reset it runs a clear sequence, and its init_done output gates CPU start-up.

Parameters:
- ADDR_WIDTH, 12, word-address bits; DEPTH = 2**ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000, byte base address of the array (aligned to DEPTH*4).
- OOR_DATA, 32'hDEAD_BEEF, data returned for an out-of-range read.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip the clear.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- inst_sram_en  in  1  instruction read strobe.
- inst_sram_addr  in  32  instruction byte address.
- inst_sram_rdata  out  32  instruction read data.
- data_sram_en  in  1  data access strobe.
- data_sram_wen  in  4  byte-lane write enables; bit i selects bits 8i+7:8i.
- data_sram_addr  in  32  data byte address.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  data read data.
- init_done  out  1  array ready for accesses.
- oor_err  out  1  sticky flag: an out-of-range access has occurred.

Behaviour:
- Reset is synchronous and active-high on clk; a single clock clk drives everything.
- Reset values: inst_sram_rdata=0, data_sram_rdata=0, init_done=0, oor_err=0, FSM=INIT, clear counter=0.
- Word index = addr[ADDR_WIDTH+1:2]. addr[1:0] is ignored; there is no alignment check.
- An address is in range iff addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2].
- FSM states:
  - INIT: writes 0 to mem[cnt] each cycle and increments cnt. When cnt==DEPTH-1 it goes to READY, so a clear takes exactly DEPTH cycles. If CLEAR_ON_RESET=0, INIT lasts 1 cycle and memory is untouched.
  - READY: init_done=1 from the first READY cycle. The FSM stays in READY until rst.
- During INIT, port strobes are ignored: no writes occur, rdata outputs hold 0, and oor_err is not updated.
- Read (READY, en=1, in range): rdata in cycle N+1 = mem[index] as it was before any write in cycle N (read-first).
- rdata registers hold their value while en=0.
- Write (READY, data_sram_en=1, wen!=0, in range): each lane with wen[i]=1 is updated at the end of the cycle; the other lanes are preserved. A data access with wen!=0 also returns the old word on data_sram_rdata the next cycle.
- Same-cycle collision (inst read and data write to the same word): inst_sram_rdata returns the old word. The write takes effect.
- Out-of-range access with en=1: rdata next cycle = OOR_DATA, the write is dropped, and oor_err is set to 1 until rst.
- rst asserted mid-INIT restarts the clear from cnt=0. rst in READY returns to INIT and re-clears when CLEAR_ON_RESET=1. Accesses in the rst cycle have no effect.

Optional Feature:
- Macro: SRAM_ACCESS_STATS_EN.
- Defined: adds three outputs, each 32 bits and saturating: stat_inst_reads, stat_data_reads (en=1, wen==0) and stat_data_writes (en=1, wen!=0).
  - Counters increment only in READY, for in-range accesses.
  - Counters reset to 0 on rst.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- defines.vh gets: `WORD_WIDTH reuse, SRAM_ST_INIT / SRAM_ST_READY state encodings, SRAM_WEN_NONE (4'b0000).
- One sub-module, sram_core:
  - Contents: the array with 1 read port, 1 read/write port and byte-lane writes, plus the registered rdata outputs.
  - Ports also carry a clear-write port, muxed onto the write path during INIT.
- The FSM, range decode, oor_err and the stats counters stay in sram_responder.

Test Plan (ADDR_WIDTH=4, BASE_ADDR=0, CLEAR_ON_RESET=1):
- Clear sequence:
  - Stimulus: preload mem with 32'hFFFF_FFFF, pulse rst for 1 cycle.
  - Required: init_done rises exactly 16 cycles after rst deasserts, and reads of 0x00..0x3C all return 0.
- Byte-lane write:
  - Stimulus: write 32'h1122_3344 wen=4'b1111 to 0x08; then write 32'hAAAA_AAAA wen=4'b0101; then read 0x08.
  - Required: data_sram_rdata = 32'h11AA_33AA, exactly 1 cycle after the read strobe.
- Read-first collision:
  - Stimulus: with mem[3]=32'h5, drive data write 32'h9 to 0x0C and inst read of 0x0C in the same cycle.
  - Required: inst_sram_rdata=32'h5 next cycle, and 32'h9 on the following inst read.
- Out-of-range:
  - Stimulus: data write to 0x40 with wdata=32'h7, then read 0x40.
  - Required: rdata=32'hDEAD_BEEF, oor_err=1 and stays 1, and mem[0] is unchanged.
- Reset mid-clear:
  - Stimulus: assert rst at INIT cycle 7.
  - Required: init_done stays 0 for 16 further cycles, and strobes issued during INIT produce rdata=0 with no write.
- Stats (SRAM_ACCESS_STATS_EN defined):
  - Stimulus: 3 inst reads, 2 data reads, 1 in-range write and 1 OOR write.
  - Required: counters read 3/2/1.

Source files
------------

// File: rtl/sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// sram_responder_pkg
// Shared types and constants for the SRAM responder slice: word width,
// responder FSM state encoding, the "no byte lanes" write-enable value and a
// byte-lane merge helper used by the storage core.
// No ports (package).
// -----------------------------------------------------------------------------
package sram_responder_pkg;

  localparam int WORD_WIDTH = 32;

  localparam logic [3:0] SRAM_WEN_NONE = 4'b0000;

  typedef enum logic {
    SRAM_ST_INIT  = 1'b0,
    SRAM_ST_READY = 1'b1
  } sramState_t;

  // Replace only the byte lanes selected by laneMask; the rest keep oldWord.
  function automatic logic [WORD_WIDTH-1:0] mergeLanes(
    input logic [WORD_WIDTH-1:0] oldWord,
    input logic [WORD_WIDTH-1:0] newWord,
    input logic [3:0]            laneMask
  );
    logic [WORD_WIDTH-1:0] merged;
    merged = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (laneMask[b]) begin
        merged[8*b +: 8] = newWord[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_responder_if.sv
// -----------------------------------------------------------------------------
// sram_responder_if
// Bundles the CPU's two SRAM initiator ports.
//   inst_sram_en / inst_sram_addr   : instruction read strobe and byte address
//   inst_sram_rdata                 : instruction read data (1-cycle latency)
//   data_sram_en / data_sram_wen    : data strobe and byte-lane write enables
//   data_sram_addr / data_sram_wdata: data byte address and write data
//   data_sram_rdata                 : data read data (1-cycle latency)
// Modports: master (CPU side), slave (responder side).
// -----------------------------------------------------------------------------
interface sram_responder_if;
  import sram_responder_pkg::*;

  logic                  inst_sram_en;
  logic [WORD_WIDTH-1:0] inst_sram_addr;
  logic [WORD_WIDTH-1:0] inst_sram_rdata;

  logic                  data_sram_en;
  logic [3:0]            data_sram_wen;
  logic [WORD_WIDTH-1:0] data_sram_addr;
  logic [WORD_WIDTH-1:0] data_sram_wdata;
  logic [WORD_WIDTH-1:0] data_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_addr,
    input  inst_sram_rdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  inst_sram_en, inst_sram_addr,
    output inst_sram_rdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );

endinterface

// File: rtl/sram_responder_core.sv
// -----------------------------------------------------------------------------
// sram_core
// Word-organised storage array with one read port (instruction) and one
// read/write port (data, byte-lane writes), plus the registered read-data
// outputs. A clear-write port takes over the write path while the responder
// is initialising.
//   clk, rst                  : clock, synchronous active-high reset (rdata only)
//   instEn/instIdx/instInRange: instruction read request (already qualified)
//   dataEn/dataWen/dataIdx/dataInRange/dataWdata : data access request
//   clrEn/clrIdx              : clear-write of zero to clrIdx
//   instRdata/dataRdata       : registered read data, hold when not enabled
// -----------------------------------------------------------------------------
module sram_core
  import sram_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [WORD_WIDTH-1:0] OOR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instEn,
  input  logic [ADDR_WIDTH-1:0] instIdx,
  input  logic                  instInRange,
  input  logic                  dataEn,
  input  logic [3:0]            dataWen,
  input  logic [ADDR_WIDTH-1:0] dataIdx,
  input  logic                  dataInRange,
  input  logic [WORD_WIDTH-1:0] dataWdata,
  input  logic                  clrEn,
  input  logic [ADDR_WIDTH-1:0] clrIdx,
  output logic [WORD_WIDTH-1:0] instRdata,
  output logic [WORD_WIDTH-1:0] dataRdata
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic                  wrEn;
  logic [ADDR_WIDTH-1:0] wrIdx;
  logic [WORD_WIDTH-1:0] wrData;
  logic [3:0]            wrMask;

  // Single write path: the clear sequence owns it during init, otherwise an
  // in-range data access with at least one lane enabled drives it.
  always_comb begin
    wrEn   = 1'b0;
    wrIdx  = dataIdx;
    wrData = dataWdata;
    wrMask = SRAM_WEN_NONE;
    if (clrEn) begin
      wrEn   = 1'b1;
      wrIdx  = clrIdx;
      wrData = '0;
      wrMask = 4'b1111;
    end else if (dataEn && dataInRange && (dataWen != SRAM_WEN_NONE)) begin
      wrEn   = 1'b1;
      wrMask = dataWen;
    end
  end

  // Array update; unselected lanes keep their previous contents.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrIdx] <= mergeLanes(mem[wrIdx], wrData, wrMask);
    end
  end

  // Read registers sample the array with non-blocking semantics, so a read
  // colliding with a write in the same cycle returns the pre-write word.
  always_ff @(posedge clk) begin
    if (rst) begin
      instRdata <= '0;
      dataRdata <= '0;
    end else begin
      if (instEn) begin
        instRdata <= instInRange ? mem[instIdx] : OOR_DATA;
      end
      if (dataEn) begin
        dataRdata <= dataInRange ? mem[dataIdx] : OOR_DATA;
      end
    end
  end

endmodule

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
// Memory-side responder for the CPU's instruction and data SRAM ports. Owns
// the init FSM (clear sequence after reset), address range decode, the sticky
// out-of-range flag and optional access statistics; storage lives in sram_core.
//   clk        : clock
//   rst        : synchronous active-high reset
//   bus        : sram_responder_if.slave (both initiator ports)
//   init_done  : array ready for accesses
//   oor_err    : sticky, an out-of-range access has occurred since reset
// Optional (macro SRAM_ACCESS_STATS_EN):
//   stat_inst_reads, stat_data_reads, stat_data_writes : saturating counters
//   of in-range accesses accepted while ready.
// -----------------------------------------------------------------------------
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 12,
  parameter logic [WORD_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [WORD_WIDTH-1:0] OOR_DATA       = 32'hDEAD_BEEF,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_responder_if.slave       bus,
  output logic                  init_done,
  output logic                  oor_err
`ifdef SRAM_ACCESS_STATS_EN
  ,
  output logic [WORD_WIDTH-1:0] stat_inst_reads,
  output logic [WORD_WIDTH-1:0] stat_data_reads,
  output logic [WORD_WIDTH-1:0] stat_data_writes
`endif
);

  sramState_t            state;
  sramState_t            stateNext;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cntNext;
  logic                  clrEn;
  logic                  ready;

  logic                  instInRange;
  logic                  dataInRange;
  logic                  instAccess;
  logic                  dataAccess;
  logic                  unusedAddrBits;

  assign ready     = (state == SRAM_ST_READY);
  assign init_done = ready;

  // An address hits the array when its bits above the word index match the
  // base; the low two byte-offset bits are deliberately ignored.
  assign instInRange = (bus.inst_sram_addr[WORD_WIDTH-1:ADDR_WIDTH+2] ==
                        BASE_ADDR[WORD_WIDTH-1:ADDR_WIDTH+2]);
  assign dataInRange = (bus.data_sram_addr[WORD_WIDTH-1:ADDR_WIDTH+2] ==
                        BASE_ADDR[WORD_WIDTH-1:ADDR_WIDTH+2]);

  assign unusedAddrBits = ^{bus.inst_sram_addr[1:0], bus.data_sram_addr[1:0]};

  // Strobes only count once the array is ready and never in a reset cycle.
  assign instAccess = ready && !rst && bus.inst_sram_en;
  assign dataAccess = ready && !rst && bus.data_sram_en;

  // State register and clear counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SRAM_ST_INIT;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // INIT walks the counter over every word writing zero, leaving on the last
  // word so the clear takes exactly DEPTH cycles; without clearing it is a
  // single pass-through cycle. READY is terminal until reset.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    clrEn     = 1'b0;
    case (state)
      SRAM_ST_INIT: begin
        clrEn   = CLEAR_ON_RESET && !rst;
        cntNext = cnt + 1'b1;
        if (!CLEAR_ON_RESET || (cnt == {ADDR_WIDTH{1'b1}})) begin
          stateNext = SRAM_ST_READY;
          cntNext   = '0;
        end
      end
      SRAM_ST_READY: begin
        stateNext = SRAM_ST_READY;
      end
      default: begin
        stateNext = SRAM_ST_INIT;
        cntNext   = '0;
      end
    endcase
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      oor_err <= 1'b0;
    end else if ((instAccess && !instInRange) || (dataAccess && !dataInRange)) begin
      oor_err <= 1'b1;
    end
  end

`ifdef SRAM_ACCESS_STATS_EN
  // Saturating counters of in-range accesses; a data access is a write when
  // any lane is enabled, otherwise a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_inst_reads  <= '0;
      stat_data_reads  <= '0;
      stat_data_writes <= '0;
    end else begin
      if (instAccess && instInRange && (stat_inst_reads != '1)) begin
        stat_inst_reads <= stat_inst_reads + 1'b1;
      end
      if (dataAccess && dataInRange) begin
        if (bus.data_sram_wen == SRAM_WEN_NONE) begin
          if (stat_data_reads != '1) begin
            stat_data_reads <= stat_data_reads + 1'b1;
          end
        end else if (stat_data_writes != '1) begin
          stat_data_writes <= stat_data_writes + 1'b1;
        end
      end
    end
  end
`endif

  sram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .OOR_DATA   (OOR_DATA)
  ) core (
    .clk         (clk),
    .rst         (rst),
    .instEn      (instAccess),
    .instIdx     (bus.inst_sram_addr[ADDR_WIDTH+1:2]),
    .instInRange (instInRange),
    .dataEn      (dataAccess),
    .dataWen     (bus.data_sram_wen),
    .dataIdx     (bus.data_sram_addr[ADDR_WIDTH+1:2]),
    .dataInRange (dataInRange),
    .dataWdata   (bus.data_sram_wdata),
    .clrEn       (clrEn),
    .clrIdx      (cnt),
    .instRdata   (bus.inst_sram_rdata),
    .dataRdata   (bus.data_sram_rdata)
  );

endmodule
